// File: rtl/bsg_dmc_trace_arbiter_if.sv
// rtl/bsg_dmc_trace_arbiter_if.sv - requester, link and read-return bundle for the trace arbiter
// slave = arbiter side, master = requesters/link environment side.
interface bsg_dmc_trace_arbiter_if #(
   parameter int num_req_p       = 2,
   parameter int payload_width_p = 64
) ();
   logic [num_req_p-1:0]                 req_v_i;
   logic [num_req_p*payload_width_p-1:0] req_data_i;
   logic [num_req_p-1:0]                 req_yumi_o;
   logic                                 link_v_o;
   logic [payload_width_p-1:0]           link_data_o;
   logic                                 link_ready_i;
   logic                                 resp_v_i;
   logic [payload_width_p-1:0]           resp_data_i;
   logic                                 resp_yumi_o;
   logic [num_req_p-1:0]                 resp_v_o;
   logic [payload_width_p-1:0]           resp_data_o;
   logic [num_req_p-1:0]                 resp_ready_i;

   modport slave (
      input  req_v_i, req_data_i, link_ready_i, resp_v_i, resp_data_i, resp_ready_i,
      output req_yumi_o, link_v_o, link_data_o, resp_yumi_o, resp_v_o, resp_data_o
   );

   modport master (
      output req_v_i, req_data_i, link_ready_i, resp_v_i, resp_data_i, resp_ready_i,
      input  req_yumi_o, link_v_o, link_data_o, resp_yumi_o, resp_v_o, resp_data_o
   );
endinterface

// File: rtl/bsg_dmc_trace_arbiter.sv
// rtl/bsg_dmc_trace_arbiter.sv - round-robin trace link arbiter with in-order read-return routing
// Optional burst lock: define BSG_DMC_TRACE_ARB_LOCK_EN.
module bsg_dmc_trace_arbiter #(
   parameter int                     num_req_p         = 2,
   parameter int                     payload_width_p   = 64,
   parameter int                     cmd_lsb_p         = 59,
   parameter int                     cmd_width_p       = 5,
   parameter logic [cmd_width_p-1:0] read_cmd_p        = cmd_width_p'(1),
   parameter int                     max_outstanding_p = 8,
   parameter int                     lock_len_p        = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   bsg_dmc_trace_arbiter_if.slave                 bus,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                   error_o
);
   localparam int id_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
   localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

   // Unsupported configurations fail elaboration on a missing module.
   if (num_req_p < 2 || lock_len_p < 1 || max_outstanding_p < 2
       || (max_outstanding_p & (max_outstanding_p - 1)) != 0) begin : g_param_check
      bsg_dmc_trace_arbiter_illegal_parameters u_bad ();
   end

   function automatic logic [id_w_lp-1:0] rr_idx(input logic [id_w_lp-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= num_req_p) s = s - num_req_p;
      return id_w_lp'(s);
   endfunction

   logic [id_w_lp-1:0]  rr_q, rr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                error_q, error_d;
   logic [id_w_lp-1:0]  mem_q [max_outstanding_p];

   logic [num_req_p-1:0] is_read, eligible;
   logic                 fifo_full, fifo_empty;
   logic                 grant_v;
   logic [id_w_lp-1:0]   grant_id;
   logic                 xfer, push, pop;
   logic [id_w_lp-1:0]   head_id;

`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
   localparam int lock_w_lp = $clog2(lock_len_p + 1);
   logic [lock_w_lp-1:0] lock_cnt_q, lock_cnt_d, lock_next;
`endif

   assign fifo_full  = (count_q == cnt_w_lp'(max_outstanding_p));
   assign fifo_empty = (count_q == '0);
   assign head_id    = mem_q[rd_ptr_q];

   // Reads are masked on the registered full flag, so a same-cycle pop never unmasks.
   always_comb begin
      is_read  = '0;
      eligible = '0;
      for (int i = 0; i < num_req_p; i++) begin
         is_read[i]  = (bus.req_data_i[i*payload_width_p + cmd_lsb_p +: cmd_width_p] == read_cmd_p);
         eligible[i] = bus.req_v_i[i] & ~(is_read[i] & fifo_full);
      end
   end

   // Walk downward so the lowest offset from the pointer wins.
   always_comb begin
      grant_v  = 1'b0;
      grant_id = rr_q;
      for (int off = num_req_p - 1; off >= 0; off--) begin
         if (eligible[rr_idx(rr_q, off)]) begin
            grant_v  = 1'b1;
            grant_id = rr_idx(rr_q, off);
         end
      end
   end

   always_comb begin
      bus.link_v_o    = grant_v & ~reset_i;
      bus.link_data_o = bus.req_data_i[int'(grant_id)*payload_width_p +: payload_width_p];
      xfer            = bus.link_v_o & bus.link_ready_i;
      bus.req_yumi_o  = '0;
      if (xfer) bus.req_yumi_o[grant_id] = 1'b1;
      push            = xfer & is_read[grant_id];
   end

   // A return with nothing outstanding is still consumed so the link never wedges.
   always_comb begin
      bus.resp_data_o = bus.resp_data_i;
      bus.resp_v_o    = '0;
      pop             = 1'b0;
      bus.resp_yumi_o = 1'b0;
      error_d         = error_q;
      if (bus.resp_v_i && !reset_i) begin
         if (fifo_empty) begin
            bus.resp_yumi_o = 1'b1;
            error_d         = 1'b1;
         end else begin
            bus.resp_v_o[head_id] = 1'b1;
            pop                   = bus.resp_ready_i[head_id];
            bus.resp_yumi_o       = pop;
         end
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
   end

`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
   // While lock_cnt_q is nonzero rr_q names the locked owner.
   always_comb begin
      rr_d       = rr_q;
      lock_cnt_d = lock_cnt_q;
      lock_next  = '0;
      if (xfer) begin
         if (lock_cnt_q != '0 && grant_id == rr_q) lock_next = lock_cnt_q + 1'b1;
         else                                     lock_next = lock_w_lp'(1);
         if (int'(lock_next) < lock_len_p) begin
            rr_d       = grant_id;
            lock_cnt_d = lock_next;
         end else begin
            rr_d       = rr_idx(grant_id, 1);
            lock_cnt_d = '0;
         end
      end else if (lock_cnt_q != '0 && !eligible[rr_q]) begin
         rr_d       = rr_idx(rr_q, 1);
         lock_cnt_d = '0;
      end
   end
`else
   always_comb begin
      rr_d = xfer ? rr_idx(grant_id, 1) : rr_q;
   end
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rr_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         error_q    <= 1'b0;
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         rr_q       <= rr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         error_q    <= error_d;
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   // Tag storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= grant_id;
   end

   assign outstanding_o = count_q;
   assign error_o       = error_q;
endmodule

// File: tb/tb_bsg_dmc_trace_arbiter.sv
// tb/tb_bsg_dmc_trace_arbiter.sv - randomized scoreboard bench for bsg_dmc_trace_arbiter
// Honours BSG_DMC_TRACE_ARB_LOCK_EN in its reference model.
module tb_bsg_dmc_trace_arbiter;
   localparam int N     = 2;
   localparam int W     = 64;
   localparam int CLSB  = 59;
   localparam int CW    = 5;
   localparam int DEPTH = 8;
   localparam int LOCK  = 4;
   localparam logic [CW-1:0] RD_OP = 5'h1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] outstanding;
   logic       error;

   bsg_dmc_trace_arbiter_if #(.num_req_p(N), .payload_width_p(W)) bus ();

   bsg_dmc_trace_arbiter #(
      .num_req_p(N), .payload_width_p(W), .cmd_lsb_p(CLSB), .cmd_width_p(CW),
      .read_cmd_p(RD_OP), .max_outstanding_p(DEPTH), .lock_len_p(LOCK)
   ) dut (
      .clk_i(clk), .reset_i(rst), .bus(bus), .outstanding_o(outstanding), .error_o(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         link_v;
      logic [W-1:0] link_data;
      logic [N-1:0] req_yumi;
      logic [N-1:0] resp_v;
      logic [W-1:0] resp_data;
      logic         resp_yumi;
      int           outstanding;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: tag FIFO as a queue of requester ids.
   int   tags_m[$];
   int   rr_m  = 0;
   bit   err_m = 0;
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
   int   last_g_m = 0;
   int   run_m    = 0;
`endif

   logic [W-1:0] pkt [N];

   function automatic bit is_rd(input logic [W-1:0] d);
      return d[CLSB +: CW] == RD_OP;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model(input bit r);
      exp_t e;
      bit   elig [N];
      int   start, g;
      bit   full;
      e.link_v = 0; e.link_data = 'x; e.req_yumi = '0; e.resp_v = '0;
      e.resp_data = bus.resp_data_i; e.resp_yumi = 0;
      if (r) begin
         tags_m.delete(); rr_m = 0; err_m = 0;
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
         last_g_m = 0; run_m = 0;
`endif
         e.outstanding = 0; e.err = 0;
         exp_q.push_back(e);
         return;
      end
      e.outstanding = tags_m.size();
      e.err         = err_m;
      full          = (tags_m.size() == DEPTH);
      for (int i = 0; i < N; i++) elig[i] = bus.req_v_i[i] && !(is_rd(pkt[i]) && full);
      start = rr_m;
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
      if (run_m > 0 && !elig[last_g_m]) run_m = 0;
      if (run_m > 0 && run_m < LOCK) start = last_g_m;
`endif
      g = -1;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && elig[(start + k) % N]) g = (start + k) % N;
      end
      if (g >= 0) begin
         e.link_v    = 1;
         e.link_data = pkt[g];
         if (bus.link_ready_i) e.req_yumi[g] = 1'b1;
      end
      if (bus.resp_v_i) begin
         if (tags_m.size() == 0) begin
            e.resp_yumi = 1; err_m = 1;
         end else begin
            e.resp_v[tags_m[0]] = 1'b1;
            if (bus.resp_ready_i[tags_m[0]]) begin
               e.resp_yumi = 1;
               void'(tags_m.pop_front());
            end
         end
      end
      if (g >= 0 && bus.link_ready_i) begin
         if (is_rd(pkt[g])) tags_m.push_back(g);
`ifdef BSG_DMC_TRACE_ARB_LOCK_EN
         if (g == last_g_m && run_m > 0 && run_m < LOCK) run_m++;
         else run_m = 1;
         last_g_m = g;
`endif
         rr_m = (g + 1) % N;
      end
      exp_q.push_back(e);
   endtask

   task automatic cycle(input bit r, input int p_req, input int p_rd, input int p_lr,
                        input int p_resp, input int p_rr);
      logic [W-1:0] d;
      @(posedge clk);
      #1;
      rst = r;
      for (int i = 0; i < N; i++) begin
         d = {$urandom, $urandom};
         if (($urandom % 100) < p_rd) d[CLSB +: CW] = RD_OP;
         else if (d[CLSB +: CW] == RD_OP) d[CLSB +: CW] = 5'h2;
         pkt[i] = d;
         bus.req_v_i[i]      = (($urandom % 100) < p_req);
         bus.resp_ready_i[i] = (($urandom % 100) < p_rr);
         bus.req_data_i[i*W +: W] = d;
      end
      bus.link_ready_i = (($urandom % 100) < p_lr);
      bus.resp_v_i     = (($urandom % 100) < p_resp);
      bus.resp_data_i  = {$urandom, $urandom};
      model(r);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("link_v", W'(bus.link_v_o), W'(e.link_v));
            if (e.link_v) chk("link_data", bus.link_data_o, e.link_data);
            chk("req_yumi", W'(bus.req_yumi_o), W'(e.req_yumi));
            chk("resp_v", W'(bus.resp_v_o), W'(e.resp_v));
            chk("resp_yumi", W'(bus.resp_yumi_o), W'(e.resp_yumi));
            chk("resp_data", bus.resp_data_o, e.resp_data);
            chk("outstanding", W'(outstanding), W'(e.outstanding));
            chk("error", W'(error), W'(e.err));
         end
      end
   end

   initial begin
      bus.req_v_i = '0; bus.req_data_i = '0; bus.link_ready_i = 0;
      bus.resp_v_i = 0; bus.resp_data_i = '0; bus.resp_ready_i = '0;
      for (int i = 0; i < N; i++) pkt[i] = '0;
      repeat (3)   cycle(1, 80, 50, 80, 50, 50);
      repeat (40)  cycle(0, 100, 0, 100, 0, 100);
      repeat (10)  cycle(0, 100, 0, 0, 0, 100);
      repeat (200) cycle(0, 90, 85, 80, 8, 70);
      repeat (200) cycle(0, 40, 20, 70, 90, 80);
      repeat (300) cycle(0, 60, 50, 60, 50, 50);
      repeat (150) cycle(0, 90, 60, 90, 60, 15);
      repeat (2)   cycle(1, 90, 50, 90, 50, 50);
      repeat (20)  cycle(0, 0, 0, 100, 100, 100);
      repeat (2)   cycle(1, 50, 50, 50, 0, 50);
      repeat (300) cycle(0, 70, 50, 70, 45, 60);
      repeat (60)  cycle(0, 0, 0, 100, 100, 100);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
